rc5_stream_frontend: RTL

- Upstream control stage for the RC5 core (W=32, R=12, B=16).
- Accepts a byte-wide key stream and loads it into the core's key RAM port.
- Accepts a byte-wide data stream and assembles A/B words.
- Drives the core's level-sensitive start lines, waits for done, then presents the result on a valid/ready output handshake.

---
 rtl/rc5_stream_frontend.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rc5_stream_frontend.sv
// Byte-stream front end for an RC5-32/12/16 core: loads the key RAM, assembles A/B blocks,
// runs the core with level starts and returns the result. Define RC5_FRONTEND_TIMEOUT_EN for the RUN watchdog.
module rc5_stream_frontend #(
    parameter int W        = 32,
    parameter int B        = 16,
    parameter int B_LENGTH = $clog2(B)
`ifdef RC5_FRONTEND_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 1024
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          iKey_byte,
    input  logic                iKeyValid,
    output logic                oKeyReady,
    input  logic [7:0]          iData_byte,
    input  logic                iDataValid,
    input  logic                iDecrypt,
    output logic                oDataReady,
    output logic [7:0]          oKey_sub_i,
    output logic [B_LENGTH-1:0] oKey_address,
    output logic                oWen,
    output logic                oCoreRst,
    output logic [W-1:0]        oA,
    output logic [W-1:0]        oB,
    output logic                oStartCipher,
    output logic                oStartDecipher,
    input  logic                iDoneCipher,
    input  logic                iDoneDecipher,
    input  logic [W-1:0]        iResA,
    input  logic [W-1:0]        iResB,
    output logic [W-1:0]        oResA,
    output logic [W-1:0]        oResB,
    output logic                oResValid,
    input  logic                iResReady,
`ifdef RC5_FRONTEND_TIMEOUT_EN
    output logic                oTimeout,
`endif
    output logic                oKeyLoaded
);
    localparam int NBYTES = W / 4;
    localparam int DCNT_W = $clog2(NBYTES);
    localparam logic [B_LENGTH-1:0] KEY_LAST  = B_LENGTH'(B - 1);
    localparam logic [DCNT_W-1:0]   DATA_LAST = DCNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        CORE_RST,
        DATA,
        RUN,
        RESULT
    } state_t;

    state_t              state_q, state_d;
    logic [B_LENGTH-1:0] key_cnt_q, key_idx, key_addr_q;
    logic [DCNT_W-1:0]   data_cnt_q, data_idx;
    logic [2*W-1:0]      blk_q;
    logic [7:0]          key_byte_q;
    logic [W-1:0]        res_a_q, res_b_q;
    logic                mode_q, key_loaded_q, wen_q;
    logic                key_fire, data_fire, done_sel, timeout_hit;

    assign key_fire  = iKeyValid && oKeyReady;
    assign data_fire = iDataValid && oDataReady;
    assign done_sel  = mode_q ? iDoneDecipher : iDoneCipher;

    // A fresh key or block always starts at index 0, whatever the counters hold.
    assign key_idx  = (state_q == IDLE) ? '0 : key_cnt_q;
    assign data_idx = (state_q == IDLE) ? '0 : data_cnt_q;

`ifdef RC5_FRONTEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] run_cnt_q;
    logic            timeout_q;

    assign timeout_hit = (state_q == RUN) && !done_sel && (run_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_cnt_q <= (state_q == RUN) ? run_cnt_q + 1'b1 : '0;
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end

    assign oTimeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (key_fire)
                    state_d = KEY;
                else if (data_fire)
                    state_d = DATA;
            end
            KEY:      if (key_fire && key_idx == KEY_LAST) state_d = CORE_RST;
            CORE_RST: state_d = IDLE;
            DATA:     if (data_fire && data_idx == DATA_LAST) state_d = RUN;
            RUN: begin
                if (done_sel)
                    state_d = RESULT;
                else if (timeout_hit)
                    state_d = IDLE;
            end
            RESULT:   if (iResReady) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Key wins a same-cycle tie in IDLE by withholding data ready.
    always_comb begin
        oKeyReady      = 1'b0;
        oDataReady     = 1'b0;
        oCoreRst       = 1'b0;
        oStartCipher   = 1'b0;
        oStartDecipher = 1'b0;
        oResValid      = 1'b0;
        unique case (state_q)
            IDLE: begin
                oKeyReady  = 1'b1;
                oDataReady = key_loaded_q && !iKeyValid;
            end
            KEY:      oKeyReady = 1'b1;
            CORE_RST: oCoreRst = 1'b1;
            DATA:     oDataReady = 1'b1;
            RUN: begin
                oStartCipher   = !mode_q;
                oStartDecipher = mode_q;
            end
            RESULT:   oResValid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_cnt_q    <= '0;
            key_addr_q   <= '0;
            key_byte_q   <= '0;
            wen_q        <= 1'b0;
            key_loaded_q <= 1'b0;
            data_cnt_q   <= '0;
            blk_q        <= '0;
            mode_q       <= 1'b0;
            res_a_q      <= '0;
            res_b_q      <= '0;
        end else begin
            wen_q <= key_fire;
            if (key_fire) begin
                key_byte_q <= iKey_byte;
                key_addr_q <= key_idx;
                key_cnt_q  <= (key_idx == KEY_LAST) ? '0 : key_idx + 1'b1;
            end

            // A new key invalidates the old one; the core reset pulse marks the new one usable.
            if ((key_fire && state_q == IDLE) || timeout_hit)
                key_loaded_q <= 1'b0;
            else if (state_q == CORE_RST)
                key_loaded_q <= 1'b1;

            // Little-endian: byte n lands at bits [8n+7:8n] of {B, A}.
            if (data_fire) begin
                blk_q[{data_idx, 3'b000} +: 8] <= iData_byte;
                data_cnt_q <= (data_idx == DATA_LAST) ? '0 : data_idx + 1'b1;
                if (state_q == IDLE)
                    mode_q <= iDecrypt;
            end

            if (state_q == RUN && done_sel) begin
                res_a_q <= iResA;
                res_b_q <= iResB;
            end
        end
    end

    assign oWen         = wen_q;
    assign oKey_sub_i   = key_byte_q;
    assign oKey_address = key_addr_q;
    assign oKeyLoaded   = key_loaded_q;
    assign oA           = blk_q[W-1:0];
    assign oB           = blk_q[2*W-1:W];
    assign oResA        = res_a_q;
    assign oResB        = res_b_q;

endmodule
